// File: rtl/rr_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_write_arbiter
// Brief    : N-port round-robin arbiter for the FIFO write path; falling-edge
//            registered one-hot grants, full gating, completed-grant counter.
// Revision : 1.0 - initial release
// ============================================================================
module rr_write_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 1,
    parameter int CW  = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   treq,
    input  logic           full,
    output logic [N-1:0]   tgrant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic [CW-1:0]  txn_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    localparam logic [IDW-1:0] c_LAST = IDW'(N - 1);
    localparam logic [N-1:0]   c_ONE  = N'(1);

    state_t         r_state;
    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   r_tgrant;
    logic           r_grant_valid;
    logic [IDW-1:0] r_grant_id;
    logic [CW-1:0]  r_txn_count;

    logic           w_pick_any;
    logic [IDW-1:0] w_pick_id;
    logic [IDW-1:0] w_cand;
    int             w_sum;

    // Walk from the highest offset down so the nearest requester after ptr wins.
    always_comb begin
        w_pick_any = 1'b0;
        w_pick_id  = '0;
        w_cand     = '0;
        w_sum      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum  = int'(r_ptr) + k;
            w_cand = (w_sum >= N) ? IDW'(w_sum - N) : IDW'(w_sum);
            if (treq[w_cand]) begin
                w_pick_any = 1'b1;
                w_pick_id  = w_cand;
            end
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_tgrant      <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_txn_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!full && w_pick_any) begin
                        r_state       <= ST_GRANT;
                        r_tgrant      <= c_ONE << w_pick_id;
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_pick_id;
                    end
                end
                ST_GRANT: begin
                    // Grants are never preempted; only the owner's request matters.
                    if (!treq[r_grant_id]) begin
                        r_state       <= ST_RELEASE;
                        r_tgrant      <= '0;
                        r_grant_valid <= 1'b0;
                        r_ptr         <= (r_grant_id == c_LAST) ? '0 : r_grant_id + IDW'(1);
                        r_txn_count   <= r_txn_count + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_tgrant      <= '0;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign tgrant      = r_tgrant;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign txn_count   = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_rr_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_write_arbiter
// Brief    : Self-checking bench for rr_write_arbiter with a grant scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_write_arbiter;

    localparam int N   = 2;
    localparam int IDW = 1;
    localparam int CW  = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   treq  = '0;
    logic           full  = 1'b0;
    logic [N-1:0]   tgrant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [CW-1:0]  txn_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [N-1:0] exp_q[$];

    rr_write_arbiter #(.N(N), .IDW(IDW), .CW(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .treq        (treq),
        .full        (full),
        .tgrant      (tgrant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .txn_count   (txn_count)
    );

    always #5 clock = ~clock;

    // Outputs move on the falling edge; look at them just after the rising edge.
    task automatic sample();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        treq  = '0;
        full  = 1'b0;
        exp_q.delete();
        sample();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_cmp++;
        if (tgrant !== 2'b00) begin n_err++; $display("FAIL reset_tgrant: got %b want 00", tgrant); end
        n_cmp++;
        if (grant_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
        n_cmp++;
        if (grant_id !== 1'b0) begin n_err++; $display("FAIL reset_id: got %0d want 0", grant_id); end
        n_cmp++;
        if (txn_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", txn_count); end
    endtask

    task automatic test_single();
        logic [N-1:0] e;
        do_reset();
        treq = 2'b01;
        exp_q.push_back(2'b01);
        sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (tgrant !== e) begin n_err++; $display("FAIL single_grant: got %b want %b", tgrant, e); end
        n_cmp++;
        if (grant_id !== 1'b0 || grant_valid !== 1'b1) begin
            n_err++; $display("FAIL single_id_valid: got id=%0d v=%b want id=0 v=1", grant_id, grant_valid);
        end
        treq = 2'b00;
        sample();
        n_cmp++;
        if (tgrant !== 2'b00 || grant_valid !== 1'b0) begin
            n_err++; $display("FAIL single_release: got %b v=%b want 00 v=0", tgrant, grant_valid);
        end
        n_cmp++;
        if (txn_count !== 8'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", txn_count); end
        sample();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] prev, pend, e;
        int  age, zrun, grants;
        bit  done;
        do_reset();
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        treq = 2'b11;
        prev = '0; pend = '0; age = 0; zrun = 0; grants = 0; done = 0;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            sample();
            if (tgrant !== 2'b00 && prev === 2'b00) begin
                grants++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL b2b_extra_grant: got %b want none", tgrant);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (tgrant !== e) begin n_err++; $display("FAIL b2b_order: got %b want %b", tgrant, e); end
                end
                if (grants > 1) begin
                    n_cmp++;
                    if (zrun < 2) begin n_err++; $display("FAIL b2b_gap: got %0d idle edges want >=2", zrun); end
                end
                age = 0;
            end else if (tgrant !== 2'b00) begin
                age++;
            end
            if (tgrant === 2'b00 && prev !== 2'b00 && grants == 4) begin
                n_cmp++;
                if (txn_count !== 8'd4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", txn_count); end
                treq = 2'b00;
                pend = '0;
                done = 1;
            end else begin
                if (pend != 0) begin treq = treq | pend; pend = '0; end
                if (tgrant !== 2'b00 && age == 3) begin treq = treq & ~tgrant; pend = tgrant; end
            end
            if (tgrant === 2'b00) zrun++; else zrun = 0;
            prev = tgrant;
        end
        if (!done) begin
            n_cmp++; n_err++; $display("FAIL b2b_timeout: got %0d grants want 4", grants);
        end
        sample();
        sample();
    endtask

    task automatic test_full_block();
        logic [N-1:0] e;
        do_reset();
        full = 1'b1;
        treq = 2'b01;
        for (int i = 0; i < 10; i++) begin
            sample();
            n_cmp++;
            if (tgrant !== 2'b00) begin n_err++; $display("FAIL full_hold_%0d: got %b want 00", i, tgrant); end
        end
        n_cmp++;
        if (txn_count !== 8'd0) begin n_err++; $display("FAIL full_count: got %0d want 0", txn_count); end
        full = 1'b0;
        exp_q.push_back(2'b01);
        sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (tgrant !== e) begin n_err++; $display("FAIL full_unblock: got %b want %b", tgrant, e); end
        treq = 2'b00;
        sample();
        sample();
        // A request that comes and goes entirely while full must leave no trace.
        full = 1'b1;
        treq = 2'b01;
        sample();
        sample();
        treq = 2'b00;
        sample();
        full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_cmp++;
            if (tgrant !== 2'b00) begin n_err++; $display("FAIL full_pulse_%0d: got %b want 00", i, tgrant); end
        end
        n_cmp++;
        if (txn_count !== 8'd1) begin n_err++; $display("FAIL full_pulse_count: got %0d want 1", txn_count); end
    endtask

    task automatic test_no_preempt();
        logic [N-1:0] e;
        int zeros;
        bit seen;
        do_reset();
        treq = 2'b01;
        exp_q.push_back(2'b01);
        sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (tgrant !== e) begin n_err++; $display("FAIL np_first: got %b want %b", tgrant, e); end
        full = 1'b1;
        treq = 2'b11;
        for (int i = 0; i < 5; i++) begin
            sample();
            n_cmp++;
            if (tgrant !== 2'b01) begin n_err++; $display("FAIL np_hold_%0d: got %b want 01", i, tgrant); end
        end
        treq = 2'b10;
        full = 1'b0;
        exp_q.push_back(2'b10);
        zeros = 0;
        seen  = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            sample();
            if (tgrant !== 2'b00) seen = 1; else zeros++;
        end
        if (!seen) begin
            n_cmp++; n_err++; $display("FAIL np_timeout: got 00 want 10");
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (tgrant !== e || zeros < 2) begin
                n_err++; $display("FAIL np_second: got %b after %0d idle want %b after >=2", tgrant, zeros, e);
            end
        end
        treq = 2'b00;
        sample();
        sample();
        n_cmp++;
        if (grant_id !== 1'b1 || grant_valid !== 1'b0) begin
            n_err++; $display("FAIL np_idle_id: got id=%0d v=%b want id=1 v=0", grant_id, grant_valid);
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [N-1:0] e;
        do_reset();
        treq = 2'b01;
        exp_q.push_back(2'b01);
        sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (tgrant !== e) begin n_err++; $display("FAIL rst_pre_grant: got %b want %b", tgrant, e); end
        treq = 2'b00;
        sample();
        sample();
        treq = 2'b10;
        exp_q.push_back(2'b10);
        sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (tgrant !== e || grant_id !== 1'b1) begin
            n_err++; $display("FAIL rst_grant1: got %b id=%0d want %b id=1", tgrant, grant_id, e);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (tgrant !== 2'b00 || grant_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_async_grant: got %b v=%b want 00 v=0", tgrant, grant_valid);
        end
        n_cmp++;
        if (grant_id !== 1'b0 || txn_count !== 8'd0) begin
            n_err++; $display("FAIL rst_async_state: got id=%0d cnt=%0d want id=0 cnt=0", grant_id, txn_count);
        end
        sample();
        reset = 1'b0;
        treq  = 2'b11;
        exp_q.push_back(2'b01);
        sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (tgrant !== e) begin n_err++; $display("FAIL rst_after_prio: got %b want %b", tgrant, e); end
        treq = 2'b00;
        sample();
        sample();
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int t = 1; t <= 257; t++) begin
            treq = 2'b01;
            sample();
            treq = 2'b00;
            sample();
            if (t == 255) begin
                n_cmp++;
                if (txn_count !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d want 255", txn_count); end
            end
            if (t == 256) begin
                n_cmp++;
                if (txn_count !== 8'd0) begin n_err++; $display("FAIL wrap_256: got %0d want 0", txn_count); end
            end
            if (t == 257) begin
                n_cmp++;
                if (txn_count !== 8'd1) begin n_err++; $display("FAIL wrap_257: got %0d want 1", txn_count); end
            end
            sample();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_block();
        test_no_preempt();
        test_reset_mid_grant();
        test_count_wrap();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
